// File: rtl/id_issue_reg.sv
// id_issue_reg: decode-to-execute issue register for the 5-stage MIPS pipeline.
// Resolves operand hazards against downstream stages with Tuse/Tnew timing,
// forwards ready results into the operand latches, inserts bubbles on stalls,
// and honours ready/valid back-pressure, flush and a saturating stall counter.
module id_issue_reg #(
   parameter int unsigned      DW      = 32,
   parameter int unsigned      AW      = 5,
   parameter int unsigned      NSRC    = 2,
   parameter int unsigned      NFWD    = 3,
   parameter int unsigned      TW      = 3,
   parameter int unsigned      PAYW    = 60,
   parameter logic [PAYW-1:0]  NOP_PAY = PAYW'(1),
   parameter logic [DW-1:0]    RST_PC  = DW'(32'h3000)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NSRC*AW-1:0]   in_raddr,
   input  logic [NSRC*DW-1:0]   in_rdata,
   input  logic [NSRC*TW-1:0]   in_tuse,
   input  logic [AW-1:0]        in_waddr,
   input  logic [TW-1:0]        in_tnew,
   input  logic [PAYW-1:0]      in_payload,
   input  logic [DW-1:0]        in_pc,
   input  logic                 in_exc,
   input  logic [4:0]           in_exccode,
   input  logic                 in_md,
   input  logic                 md_busy,
   input  logic [NFWD*AW-1:0]   fwd_addr,
   input  logic [NFWD*TW-1:0]   fwd_tnew,
   input  logic [NFWD*DW-1:0]   fwd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NSRC*AW-1:0]   out_raddr,
   output logic [NSRC*DW-1:0]   out_rdata,
   output logic [NSRC-1:0]      out_pend,
   output logic [NSRC*TW-1:0]   out_tuse,
   output logic [AW-1:0]        out_waddr,
   output logic [TW-1:0]        out_tnew,
   output logic [PAYW-1:0]      out_payload,
   output logic [DW-1:0]        out_pc,
   output logic                 out_exc,
   output logic [4:0]           out_exccode,
   output logic [31:0]          stall_cnt
);

   logic [NSRC-1:0]    src_haz;
   logic [NSRC-1:0]    nxt_pend;
   logic [NSRC*DW-1:0] nxt_rdata;
   logic [NSRC*TW-1:0] nxt_tuse;
   logic [TW-1:0]      nxt_tnew;
   logic               hazard;
   logic               adv;
   logic               load;

   // per-operand scratch used inside the resolution loop
   logic               found;
   logic [AW-1:0]      ra;
   logic [TW-1:0]      tu;
   logic [TW-1:0]      mt;
   logic [DW-1:0]      mdat;

   // Tuse: 0 stays 0 and the all-ones "unused" marker is preserved
   function automatic logic [TW-1:0] dec_tuse(input logic [TW-1:0] v);
      if (v == '0 || v == '1) return v;
      return v - TW'(1);
   endfunction

   // Tnew: saturating decrement towards 0
   function automatic logic [TW-1:0] dec_tnew(input logic [TW-1:0] v);
      if (v == '0) return v;
      return v - TW'(1);
   endfunction

   // resolve each source against the youngest matching downstream stage
   always_comb begin
      src_haz   = '0;
      nxt_pend  = '0;
      nxt_rdata = in_rdata;
      found     = 1'b0;
      ra        = '0;
      tu        = '0;
      mt        = '0;
      mdat      = '0;
      for (int unsigned s = 0; s < NSRC; s++) begin
         ra    = in_raddr[s*AW +: AW];
         tu    = in_tuse[s*TW +: TW];
         found = 1'b0;
         mt    = '0;
         mdat  = '0;
         if (ra != '0 && tu != '1) begin
            for (int unsigned k = 0; k < NFWD; k++) begin
               if (!found && fwd_addr[k*AW +: AW] == ra) begin
                  found = 1'b1;
                  mt    = fwd_tnew[k*TW +: TW];
                  mdat  = fwd_data[k*DW +: DW];
               end
            end
         end
         if (found) begin
            src_haz[s] = (mt > tu);
            if (mt == '0) begin
               nxt_rdata[s*DW +: DW] = mdat;
            end else begin
               nxt_pend[s] = 1'b1;
            end
         end
      end
   end

   // decremented timing fields for the loaded entry
   always_comb begin
      nxt_tuse = '0;
      for (int unsigned s = 0; s < NSRC; s++) begin
         nxt_tuse[s*TW +: TW] = dec_tuse(in_tuse[s*TW +: TW]);
      end
      nxt_tnew = dec_tnew(in_tnew);
   end

   // stall decision and handshake; an excepting instruction never stalls
   always_comb begin
      hazard   = !in_exc && ((|src_haz) || (in_md && md_busy));
      adv      = !out_valid || out_ready;
      in_ready = adv && !hazard && !flush;
      load     = in_valid && in_ready;
   end

   // issue register: reset/flush/empty-advance give a bubble, !adv holds
   always_ff @(posedge clk) begin
      if (!reset || flush || (adv && !load)) begin
         out_valid   <= 1'b0;
         out_raddr   <= '0;
         out_rdata   <= '0;
         out_pend    <= '0;
         out_tuse    <= '1;
         out_waddr   <= '0;
         out_tnew    <= '0;
         out_payload <= NOP_PAY;
         out_pc      <= RST_PC;
         out_exc     <= 1'b0;
         out_exccode <= 5'd31;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_raddr   <= in_raddr;
         out_rdata   <= nxt_rdata;
         out_pend    <= nxt_pend;
         out_tuse    <= nxt_tuse;
         out_waddr   <= in_waddr;
         out_tnew    <= nxt_tnew;
         out_payload <= in_payload;
         out_pc      <= in_pc;
         out_exc     <= in_exc;
         out_exccode <= in_exccode;
      end
   end

   // count cycles in which a valid decode entry is held back by a hazard
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (in_valid && hazard && !flush && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_id_issue_reg.sv
// Bench for id_issue_reg: table of decode vectors with expected handshake and
// operand results, a scoreboard checking every accepted entry, and hand-written
// sequences for reset, mult/div stall, back-pressure with flush and reset mid-stall.
module tb_id_issue_reg;

   localparam int DW = 32, AW = 5, NSRC = 2, NFWD = 3, TW = 3, PAYW = 60;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset, flush, in_valid, in_ready;
   logic [NSRC*AW-1:0]  in_raddr;
   logic [NSRC*DW-1:0]  in_rdata;
   logic [NSRC*TW-1:0]  in_tuse;
   logic [AW-1:0]       in_waddr;
   logic [TW-1:0]       in_tnew;
   logic [PAYW-1:0]     in_payload;
   logic [DW-1:0]       in_pc;
   logic                in_exc;
   logic [4:0]          in_exccode;
   logic                in_md, md_busy;
   logic [NFWD*AW-1:0]  fwd_addr;
   logic [NFWD*TW-1:0]  fwd_tnew;
   logic [NFWD*DW-1:0]  fwd_data;
   logic                out_valid, out_ready;
   logic [NSRC*AW-1:0]  out_raddr;
   logic [NSRC*DW-1:0]  out_rdata;
   logic [NSRC-1:0]     out_pend;
   logic [NSRC*TW-1:0]  out_tuse;
   logic [AW-1:0]       out_waddr;
   logic [TW-1:0]       out_tnew;
   logic [PAYW-1:0]     out_payload;
   logic [DW-1:0]       out_pc;
   logic                out_exc;
   logic [4:0]          out_exccode;
   logic [31:0]         stall_cnt;

   id_issue_reg dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_raddr(in_raddr), .in_rdata(in_rdata), .in_tuse(in_tuse), .in_waddr(in_waddr),
      .in_tnew(in_tnew), .in_payload(in_payload), .in_pc(in_pc), .in_exc(in_exc),
      .in_exccode(in_exccode), .in_md(in_md), .md_busy(md_busy), .fwd_addr(fwd_addr),
      .fwd_tnew(fwd_tnew), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_raddr(out_raddr), .out_rdata(out_rdata), .out_pend(out_pend), .out_tuse(out_tuse),
      .out_waddr(out_waddr), .out_tnew(out_tnew), .out_payload(out_payload), .out_pc(out_pc),
      .out_exc(out_exc), .out_exccode(out_exccode), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [4:0]  ra0, ra1;
      logic [2:0]  tu0, tu1;
      logic [31:0] rd0, rd1;
      logic [14:0] fa;
      logic [8:0]  ft;
      logic [95:0] fd;
      logic        md, busy, exc;
      logic [4:0]  ecode;
      logic        e_rdy;
      logic [31:0] e_d0, e_d1;
      logic [1:0]  e_pend;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      logic [1:0]  pend;
      logic [9:0]  raddr;
      logic [5:0]  tuse;
      logic        chk_tuse;
      logic [4:0]  waddr;
      logic [2:0]  tnew;
      logic [59:0] payload;
      logic [31:0] pc;
      logic        exc;
      logic [4:0]  ecode;
   } exp_t;

   exp_t sbq[$];
   vec_t vt[15];
   int   checks = 0;
   int   errors = 0;
   int   stall_exp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic vec_t base(input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic [2:0] tu0, input logic [2:0] tu1);
      vec_t v;
      v.ra0 = ra0; v.ra1 = ra1; v.tu0 = tu0; v.tu1 = tu1;
      v.rd0 = 32'hAAAA_0000 + 32'(ra0);
      v.rd1 = 32'hBBBB_0000 + 32'(ra1);
      v.fa = '0; v.ft = '0; v.fd = '0;
      v.md = 1'b0; v.busy = 1'b0; v.exc = 1'b0; v.ecode = 5'd31;
      v.e_rdy = 1'b1; v.e_d0 = v.rd0; v.e_d1 = v.rd1; v.e_pend = 2'b00;
      return v;
   endfunction

   function automatic vec_t fw(input vec_t vi, input int k, input logic [4:0] a,
                               input logic [2:0] t, input logic [31:0] d);
      vec_t v = vi;
      v.fa[k*5 +: 5]  = a;
      v.ft[k*3 +: 3]  = t;
      v.fd[k*32 +: 32] = d;
      return v;
   endfunction

   function automatic logic [2:0] dec(input logic [2:0] t);
      return (t == 3'd0) ? 3'd0 : t - 3'd1;
   endfunction

   // drive one decode entry; check in_ready and queue the expected latch contents
   task automatic apply(input vec_t v, input int tag);
      exp_t e;
      in_valid   = 1'b1;
      in_raddr   = {v.ra1, v.ra0};
      in_rdata   = {v.rd1, v.rd0};
      in_tuse    = {v.tu1, v.tu0};
      fwd_addr   = v.fa;
      fwd_tnew   = v.ft;
      fwd_data   = v.fd;
      in_md      = v.md;
      md_busy    = v.busy;
      in_exc     = v.exc;
      in_exccode = v.ecode;
      in_pc      = 32'h4000 + 32'(tag * 4);
      in_payload = 60'(tag * 3 + 100);
      in_waddr   = 5'(tag % 31 + 1);
      in_tnew    = 3'(tag % 4 + 1);
      #1;
      chk($sformatf("in_ready[%0d]", tag), in_ready, v.e_rdy);
      if (v.e_rdy) begin
         e.rdata    = {v.e_d1, v.e_d0};
         e.pend     = v.e_pend;
         e.raddr    = {v.ra1, v.ra0};
         e.tuse     = {dec(v.tu1), dec(v.tu0)};
         e.chk_tuse = (v.tu0 != 3'd7) && (v.tu1 != 3'd7);
         e.waddr    = 5'(tag % 31 + 1);
         e.tnew     = 3'(tag % 4);
         e.payload  = 60'(tag * 3 + 100);
         e.pc       = 32'h4000 + 32'(tag * 4);
         e.exc      = v.exc;
         e.ecode    = v.ecode;
         sbq.push_back(e);
      end
   endtask

   // scoreboard: every accepted entry must appear in the register after the edge
   initial begin
      logic acc;
      exp_t e;
      forever begin
         @(posedge clk);
         acc = reset && in_valid && in_ready;
         #1;
         if (acc) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_accept: got accept expected none at pc %0h", out_pc);
            end else begin
               e = sbq.pop_front();
               chk("sb_valid",   out_valid,   1'b1);
               chk("sb_rdata",   out_rdata,   e.rdata);
               chk("sb_pend",    out_pend,    e.pend);
               chk("sb_raddr",   out_raddr,   e.raddr);
               if (e.chk_tuse) chk("sb_tuse", out_tuse, e.tuse);
               chk("sb_waddr",   out_waddr,   e.waddr);
               chk("sb_tnew",    out_tnew,    e.tnew);
               chk("sb_payload", out_payload, e.payload);
               chk("sb_pc",      out_pc,      e.pc);
               chk("sb_exc",     out_exc,     e.exc);
               chk("sb_exccode", out_exccode, e.ecode);
            end
         end
      end
   end

   initial begin
      vec_t v;
      // vector table
      vt[0]  = base(5'd1, 5'd2, 3'd1, 3'd1);
      v = fw(base(5'd8, 5'd3, 3'd1, 3'd1), 0, 5'd8, 3'd0, 32'hDEAD); v.e_d0 = 32'hDEAD; vt[1] = v;
      v = fw(base(5'd8, 5'd3, 3'd1, 3'd1), 0, 5'd8, 3'd2, 32'h0);    v.e_rdy = 1'b0;    vt[2] = v;
      v = fw(base(5'd8, 5'd3, 3'd1, 3'd1), 0, 5'd8, 3'd0, 32'hDEAD); v.e_d0 = 32'hDEAD; vt[3] = v;
      v = fw(fw(base(5'd9, 5'd3, 3'd1, 3'd1), 0, 5'd9, 3'd0, 32'h1), 1, 5'd9, 3'd0, 32'h2);
      v.e_d0 = 32'h1; vt[4] = v;
      v = fw(fw(base(5'd9, 5'd3, 3'd0, 3'd1), 0, 5'd9, 3'd0, 32'h5), 1, 5'd9, 3'd3, 32'h6);
      v.e_d0 = 32'h5; vt[5] = v;
      v = fw(base(5'd1, 5'd7, 3'd1, 3'd2), 2, 5'd7, 3'd2, 32'h77); v.e_pend = 2'b10; vt[6] = v;
      v = fw(fw(fw(base(5'd0, 5'd0, 3'd0, 3'd0), 0, 5'd0, 3'd3, 32'h10), 1, 5'd0, 3'd3, 32'h20),
             2, 5'd0, 3'd3, 32'h30);
      vt[7] = v;
      vt[8]  = fw(base(5'd4, 5'd2, 3'd7, 3'd1), 0, 5'd4, 3'd5, 32'h44);
      v = fw(base(5'd8, 5'd3, 3'd1, 3'd1), 0, 5'd8, 3'd2, 32'h0);
      v.exc = 1'b1; v.ecode = 5'd10; v.e_pend = 2'b01; vt[9] = v;
      v = base(5'd1, 5'd2, 3'd1, 3'd1); v.md = 1'b1; v.busy = 1'b1; v.e_rdy = 1'b0; vt[10] = v;
      v = base(5'd1, 5'd2, 3'd1, 3'd1); v.md = 1'b1; vt[11] = v;
      v = fw(base(5'd1, 5'd6, 3'd1, 3'd1), 1, 5'd6, 3'd2, 32'h0); v.e_rdy = 1'b0; vt[12] = v;
      v = fw(base(5'd1, 5'd6, 3'd1, 3'd2), 1, 5'd6, 3'd2, 32'h66); v.e_pend = 2'b10; vt[13] = v;
      v = fw(base(5'd5, 5'd2, 3'd0, 3'd1), 2, 5'd5, 3'd1, 32'h0); v.e_rdy = 1'b0; vt[14] = v;

      // reset: two cycles low, bubble contents expected
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_raddr = '0; in_rdata = '0; in_tuse = '1; in_waddr = '0; in_tnew = '0;
      in_payload = '0; in_pc = '0; in_exc = 1'b0; in_exccode = 5'd31;
      in_md = 1'b0; md_busy = 1'b0; fwd_addr = '0; fwd_tnew = '0; fwd_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid",   out_valid,   1'b0);
      chk("rst_pc",      out_pc,      32'h3000);
      chk("rst_tuse",    out_tuse,    6'h3F);
      chk("rst_stall",   stall_cnt,   32'd0);
      chk("rst_payload", out_payload, 60'd1);
      chk("rst_exccode", out_exccode, 5'd31);
      chk("rst_rdata",   out_rdata,   64'd0);
      @(negedge clk) reset = 1'b1;

      // table-driven vectors, one per cycle with execute always ready
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         apply(vt[i], i);
         if (!vt[i].e_rdy) stall_exp++;
      end
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk) #1;
      chk("stall_after_table", stall_cnt, 32'(stall_exp));

      // mult/div busy for four cycles, then the unit frees up
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         apply(vt[10], 20);
         stall_exp++;
      end
      @(negedge clk) apply(vt[11], 21);
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk) #1;
      chk("stall_after_md", stall_cnt, 32'(stall_exp));

      // back-pressure hold then flush
      @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk) out_ready = 1'b0;
      apply(vt[0], 30);
      @(negedge clk);
      v = vt[1]; v.e_rdy = 1'b0;
      apply(v, 31);
      @(posedge clk) #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_pc",    out_pc,    32'h4000 + 32'(30 * 4));
      @(negedge clk) flush = 1'b1;
      #1 chk("flush_in_ready", in_ready, 1'b0);
      @(posedge clk) #1;
      chk("flush_valid",   out_valid,   1'b0);
      chk("flush_payload", out_payload, 60'd1);
      chk("flush_pc",      out_pc,      32'h3000);
      chk("flush_stall",   stall_cnt,   32'(stall_exp));
      @(negedge clk) flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

      // reset taken while a hazard stall is in progress
      @(negedge clk) apply(vt[2], 40);
      stall_exp++;
      @(posedge clk) #1;
      chk("midstall_cnt", stall_cnt, 32'(stall_exp));
      @(negedge clk) reset = 1'b0;
      @(posedge clk) #1;
      chk("midrst_stall", stall_cnt, 32'd0);
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_tuse",  out_tuse,  6'h3F);
      @(negedge clk) reset = 1'b1; in_valid = 1'b0;
      @(posedge clk) #1;
      chk("post_rst_stall", stall_cnt, 32'd0);

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
